// File: rtl/limit_seq_pkg.sv
// Shared definitions for the limit-select sequencer: FSM state encoding,
// select width and the default period-limit width.
package limit_seq_pkg;

  localparam int SEL_W              = 2;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int STEP_W             = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } state_e;

  function automatic logic [SEL_W-1:0] sel_wrap_inc(input logic [SEL_W-1:0] s);
    return s + SEL_W'(1);
  endfunction

endpackage

// File: rtl/limit_sel_sequencer_if.sv
// Run-control and select/limit bus between the sequencer and its environment
// (external limit mux plus mode/enable sources).
interface limit_sel_sequencer_if #(
  parameter int DATA_WIDTH = limit_seq_pkg::DEFAULT_DATA_WIDTH
);
  logic                             i_en;
  logic                             i_auto;
  logic [limit_seq_pkg::SEL_W-1:0]  i_sw;
  logic [DATA_WIDTH-1:0]            i_limit;
  logic [limit_seq_pkg::SEL_W-1:0]  o_sel;
  logic                             o_tick;
  logic                             o_busy;

  modport slave (
    input  i_en, i_auto, i_sw, i_limit,
    output o_sel, o_tick, o_busy
  );

  modport master (
    output i_en, i_auto, i_sw, i_limit,
    input  o_sel, o_tick, o_busy
  );
endinterface

// File: rtl/period_counter.sv
// Free-running period counter with synchronous clear, count enable and a
// terminal-count flag raised while the count equals i_limit-1.
module period_counter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_limit,
  output logic                  o_tc
);

  logic [DATA_WIDTH-1:0] r_cnt;

  assign o_tc = (r_cnt == (i_limit - DATA_WIDTH'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/limit_sel_sequencer.sv
// Sequences a 2-bit select through an external limit mux, ticking at each period end.
// Optional tick counter output enabled by defining LIMIT_SEL_SEQ_TICK_CNT_EN.
module limit_sel_sequencer
  import limit_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int STEP_TICKS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  limit_sel_sequencer_if.slave  bus
`ifdef LIMIT_SEL_SEQ_TICK_CNT_EN
  ,
  output logic [15:0]           o_tick_cnt
`endif
);

  localparam logic [STEP_W-1:0] STEP_LIM = STEP_W'(STEP_TICKS);

  state_e                 r_state;
  logic [DATA_WIDTH-1:0]  r_limit_q;
  logic [STEP_W-1:0]      r_step;
  logic [SEL_W-1:0]       r_sel;
  logic                   r_tick;

  logic [DATA_WIDTH-1:0]  w_limit;
  logic                   w_cnt_en;
  logic                   w_tc;
  logic                   w_tick_now;
  logic [STEP_W-1:0]      w_step_inc;
  logic [STEP_W-1:0]      w_next_step;
  logic [SEL_W-1:0]       w_next_sel;

  assign w_limit    = bus.i_limit;
  assign w_cnt_en   = (r_state == COUNT) && bus.i_en;
  assign w_tick_now = w_cnt_en && w_tc;

  period_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_period_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!w_cnt_en),
    .i_en    (w_cnt_en),
    .i_limit (r_limit_q),
    .o_tc    (w_tc)
  );

  // Selection for the next period; only consumed on a tick edge.
  always_comb begin
    w_step_inc  = r_step + STEP_W'(1);
    w_next_sel  = r_sel;
    w_next_step = '0;
    if (bus.i_auto) begin
      if (w_step_inc == STEP_LIM) begin
        w_next_sel = sel_wrap_inc(r_sel);
      end else begin
        w_next_step = w_step_inc;
      end
    end else begin
      w_next_sel = bus.i_sw;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_limit_q <= DATA_WIDTH'(1);
      r_step    <= '0;
      r_sel     <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (!bus.i_en) begin
        r_state <= IDLE;
        r_step  <= '0;
      end else begin
        case (r_state)
          IDLE: r_state <= LOAD;
          LOAD: begin
            // A zero limit would never reach terminal count; treat it as 1.
            r_limit_q <= (w_limit == '0) ? DATA_WIDTH'(1) : w_limit;
            r_state   <= COUNT;
          end
          COUNT: begin
            if (w_tc) begin
              r_tick  <= 1'b1;
              r_sel   <= w_next_sel;
              r_step  <= w_next_step;
              r_state <= (w_next_sel != r_sel) ? LOAD : COUNT;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_sel  = r_sel;
  assign bus.o_tick = r_tick;
  assign bus.o_busy = (r_state != IDLE);

`ifdef LIMIT_SEL_SEQ_TICK_CNT_EN
  logic [15:0] r_tick_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick_now) begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign o_tick_cnt = r_tick_cnt;
`else
  logic w_tick_now_unused;
  assign w_tick_now_unused = w_tick_now;
`endif

endmodule

// File: tb/tb_limit_sel_sequencer.sv
// Bench for limit_sel_sequencer: directed scenarios plus random run, checked
// against a countdown-to-next-tick reference model of the select/period rules.
module tb_limit_sel_sequencer;
  import limit_seq_pkg::*;

  localparam int DW   = 32;
  localparam int STEP = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic force_zero;
  int   n_assert = 0;
  int   n_fail   = 0;

  limit_sel_sequencer_if #(.DATA_WIDTH(DW)) bus ();

`ifdef LIMIT_SEL_SEQ_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif

  limit_sel_sequencer #(
    .DATA_WIDTH (DW),
    .STEP_TICKS (STEP)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
`ifdef LIMIT_SEL_SEQ_TICK_CNT_EN
    ,
    .o_tick_cnt (tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mux_model(input logic [1:0] s);
    case (s)
      2'd0:    return 32'd3;
      2'd1:    return 32'd10;
      2'd2:    return 32'd100;
      default: return 32'd5000;
    endcase
  endfunction

  assign bus.i_limit = force_zero ? '0 : mux_model(bus.o_sel);

  // Reference model: number of edges remaining until the next tick.
  bit       m_busy;
  bit       m_tick;
  logic [1:0] m_sel;
  int       m_wait;
  int       m_step;
  int       m_tcnt;

  function automatic int eff_limit(input logic [1:0] s);
    int l;
    l = force_zero ? 0 : int'(mux_model(s));
    return (l == 0) ? 1 : l;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tick = 0; m_sel = 2'd0; m_wait = 0; m_step = 0; m_tcnt = 0;
  endtask

  task automatic model_edge();
    logic [1:0] ns;
    if (!rst_n) begin
      model_reset();
    end else if (!bus.i_en) begin
      m_busy = 0; m_tick = 0; m_step = 0;
    end else if (!m_busy) begin
      m_busy = 1; m_tick = 0;
      m_wait = eff_limit(m_sel) + 1;
    end else begin
      m_tick = 0;
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        m_tick = 1;
        m_tcnt = m_tcnt + 1;
        ns = m_sel;
        if (bus.i_auto) begin
          m_step = m_step + 1;
          if (m_step == STEP) begin
            ns = m_sel + 2'd1;
            m_step = 0;
          end
        end else begin
          ns = bus.i_sw;
          m_step = 0;
        end
        if (ns != m_sel) begin
          m_sel  = ns;
          m_wait = eff_limit(ns) + 1;
        end else begin
          m_wait = eff_limit(m_sel);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tick", {31'd0, bus.o_tick}, {31'd0, m_tick});
    chk("sel",  {30'd0, bus.o_sel},  {30'd0, m_sel});
    chk("busy", {31'd0, bus.o_busy}, {31'd0, m_busy});
`ifdef LIMIT_SEL_SEQ_TICK_CNT_EN
    chk("tick_cnt", {16'd0, tick_cnt}, m_tcnt & 32'hFFFF);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_tick(input string tag, input int max, output int edges,
                           output logic [1:0] period_sel);
    logic [1:0] p;
    int seen;
    seen = 0; edges = 0; period_sel = 2'd0;
    for (int k = 1; k <= max; k++) begin
      p = bus.o_sel;
      step();
      if (bus.o_tick) begin
        seen = 1; edges = k; period_sel = p;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int         tick_edges[$];
    int         e;
    logic [1:0] ps;
    int         exp_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int         r;

    rst_n = 1'b1; force_zero = 1'b0;
    bus.i_en = 1'b0; bus.i_auto = 1'b0; bus.i_sw = 2'd0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (5) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("idle_sel",  {30'd0, bus.o_sel},  0);
    chk("idle_busy", {31'd0, bus.o_busy}, 0);

    // Manual on sel 00: ticks after edges 4, 7, 10 from the enabling edge.
    bus.i_en = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      if (bus.o_tick) tick_edges.push_back(k);
    end
    chk("p3_tick_count", tick_edges.size(), 3);
    if (tick_edges.size() == 3) begin
      chk("p3_tick0", tick_edges[0], 4);
      chk("p3_tick1", tick_edges[1], 7);
      chk("p3_tick2", tick_edges[2], 10);
    end

    // Switch to 01 one cycle after a tick.
    step();
    bus.i_sw = 2'd1;
    wait_tick("sw01_tick", 20, e, ps);
    chk("sw01_sel", {30'd0, bus.o_sel}, 1);
    wait_tick("sw01_gap1", 40, e, ps);
    chk("sw01_gap_load", e, 11);
    wait_tick("sw01_gap2", 40, e, ps);
    chk("sw01_gap_steady", e, 10);

    // Back to 00 manually, then auto sweep.
    bus.i_sw = 2'd0;
    wait_tick("to00_tick", 40, e, ps);
    chk("to00_sel", {30'd0, bus.o_sel}, 0);
    bus.i_auto = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_tick("auto_tick", 6000, e, ps);
      chk("auto_seq", {30'd0, ps}, exp_seq[i]);
    end

    // Manual 10, drop enable mid-period, then re-enable.
    bus.i_auto = 1'b0;
    bus.i_sw   = 2'd2;
    wait_tick("to10_tick", 6000, e, ps);
    chk("to10_sel", {30'd0, bus.o_sel}, 2);
    repeat (40) step();
    bus.i_en = 1'b0;
    step();
    chk("endrop_busy", {31'd0, bus.o_busy}, 0);
    chk("endrop_tick", {31'd0, bus.o_tick}, 0);
    chk("endrop_sel",  {30'd0, bus.o_sel},  2);
    repeat (5) step();
    bus.i_en = 1'b1;
    step();
    wait_tick("reen_tick", 200, e, ps);
    chk("reen_first_tick", e, 101);

    // Zero limit from the mux: tick every cycle in COUNT.
    bus.i_en = 1'b0;
    step();
    force_zero = 1'b1;
    bus.i_en = 1'b1;
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("zero_lim_tick", {31'd0, bus.o_tick}, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_mid_sel",  {30'd0, bus.o_sel},  0);
    chk("rst_mid_busy", {31'd0, bus.o_busy}, 0);
    chk("rst_mid_tick", {31'd0, bus.o_tick}, 0);
    repeat (3) step();
    rst_n = 1'b1;
    force_zero = 1'b0;
    repeat (3) step();

    // Random run.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) bus.i_en = ~bus.i_en;
      else if (r < 6) bus.i_auto = 1'($urandom_range(0, 1));
      else if (r < 12) bus.i_sw = 2'($urandom_range(0, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/limit_sel_sequencer.md
LIMIT_SEL_SEQUENCER -- requirements
Module: limit_sel_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the period limit input.
REQ-002 Parameter STEP_TICKS, default 4, SHALL set the number of ticks per selection in auto mode (range 1..255).
REQ-003 i_clk  input  1  SHALL be the single clock, rising-edge active.
REQ-004 i_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_en  input  1  SHALL be the run enable.
REQ-006 i_auto  input  1  SHALL select the mode: 1 = auto sweep, 0 = manual.
REQ-007 i_sw  input  2  SHALL be the manual selection request.
REQ-008 i_limit  input  DATA_WIDTH  SHALL be the period limit returned combinationally by the external limit mux for o_sel.
REQ-009 o_sel  output  2  SHALL be the registered select driving the external limit mux.
REQ-010 o_tick  output  1  SHALL be a one-cycle registered pulse at each period end.
REQ-011 o_busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, LOAD and COUNT.
REQ-013 IDLE: counter held at 0, o_tick 0; when i_en=1 is sampled, next state SHALL be LOAD.
REQ-014 LOAD, one cycle: SHALL latch limit_q = (i_limit==0 ? 1 : i_limit), clear the counter and go to COUNT.
REQ-015 COUNT: counter SHALL increment each cycle; on a cycle with counter == limit_q-1, it SHALL register o_tick=1 and clear the counter.
REQ-016 With unchanged selection, ticks SHALL be spaced exactly limit_q cycles; the first tick SHALL be registered at edge limit_q+1 counted from the edge that samples i_en=1 (edge 0).
REQ-017 At a tick edge, the next selection SHALL be computed. Auto: step count+1; if it reaches STEP_TICKS, o_sel SHALL become o_sel+1 (wrapping 3 to 0) and the step count SHALL clear. Manual: o_sel SHALL become i_sw.
REQ-018 If o_sel changes at a tick edge, next state SHALL be LOAD, giving a limit_q+1 gap to the following tick; otherwise the FSM SHALL stay in COUNT.
REQ-019 i_auto and i_sw SHALL be sampled only at tick edges; changes between ticks SHALL be ignored until the next tick.
REQ-020 i_en=0 sampled in any state SHALL force IDLE at that edge: counter and step count cleared, no tick, o_sel retained.
REQ-021 Counter and limit_q SHALL be DATA_WIDTH bits; the counter SHALL never exceed limit_q-1.
REQ-022 A mode change from auto to manual SHALL clear the step count at the tick edge where it is sampled.

Reset
REQ-023 While i_rst_n=0: state IDLE, o_sel=2'b00, o_tick=0, o_busy=0, counter=0, step count=0, limit_q=1.
REQ-024 Reset asserted mid-COUNT SHALL take effect immediately with no pending tick; on deassertion the block SHALL resume per REQ-013.

Configuration
REQ-025 With LIMIT_SEL_SEQ_TICK_CNT_EN defined, the block SHALL add output o_tick_cnt (16 bits), incremented on every o_tick, wrapping 0xFFFF to 0, reset to 0, and not cleared by i_en=0.
REQ-026 Without LIMIT_SEL_SEQ_TICK_CNT_EN, the block SHALL have no o_tick_cnt port and no associated logic.

Structure
REQ-027 Package limit_seq_pkg SHALL hold the FSM state encoding (IDLE=0, LOAD=1, COUNT=2), SEL_W=2 and the default DATA_WIDTH.
REQ-028 Sub-module period_counter SHALL contain the DATA_WIDTH counter with clear, enable and terminal-count flag; the FSM and selection logic SHALL remain in the top level.

Verification (bench models the limit mux: sel 00/01/10/11 -> 3/10/100/5000)
REQ-029 Reset held 5 cycles, then released with i_en=0 -> o_sel=00, o_tick=0, o_busy=0 indefinitely.
REQ-030 Manual, i_sw=00, i_en raised (edge 0) -> o_tick high after edges 4, 7, 10 (period 3).
REQ-031 Manual running on 00, i_sw changed to 01 one cycle after a tick -> o_sel=01 at the next tick edge, following tick 11 cycles later, then every 10.
REQ-032 Auto, STEP_TICKS=2 -> o_sel sequence 00,00,01,01,10,10,11,11,00 across successive ticks, wrapping correctly.
REQ-033 i_en dropped mid-period on sel 10 -> next edge IDLE, no tick, o_sel stays 10; re-enable -> first tick 101 edges later.
REQ-034 Mux model forced to return 0 -> o_tick high every cycle in COUNT; reset pulsed mid-COUNT -> immediate REQ-023 values.
